// File: rtl/bus_master_arb_if.sv
// Shared-bus bundle between the two requesting masters (CPU, DMA), the arbiter
// and the peripheral side.
interface bus_master_arb_if;
  logic        m0_req;
  logic        m1_req;
  logic [31:0] m0_addr;
  logic [31:0] m1_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m1_wdata;
  logic [3:0]  m0_we;
  logic [3:0]  m1_we;
  logic        m0_gnt;
  logic        m1_gnt;
  logic [31:0] m0_rdata;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_we;
  logic [1:0]  ce;
  logic [31:0] bus_rdata;

  // Arbiter side.
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
    input  bus_rdata,
    output m0_gnt, m1_gnt, m0_rdata, m1_rdata,
    output bus_addr, bus_wdata, bus_we, ce
  );

  // Requester / peripheral side.
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
    output bus_rdata,
    input  m0_gnt, m1_gnt, m0_rdata, m1_rdata,
    input  bus_addr, bus_wdata, bus_we, ce
  );
endinterface

// File: rtl/bus_master_arb.sv
// Two-master round-robin bus arbiter with hold-time fairness, shared-bus mux
// and two-peripheral chip-enable decode.
module bus_master_arb #(
  parameter int unsigned MAX_HOLD  = 8,
  parameter logic [31:0] PER1_BASE = 32'h0000_0080
) (
  input logic             clk,
  input logic             reset,
  bus_master_arb_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic               last_owner_q, last_owner_d;
  logic               hold_expired;
  logic               any_gnt;
  logic               per1_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Saturated counters also count as expired so a late-arriving requester is
  // never starved by a holder that has already run past its slot.
  assign hold_expired = (hold_cnt_q >= CNT_W'(MAX_HOLD - 1));

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    last_owner_d = last_owner_q;

    unique case (state_q)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) state_d = last_owner_q ? GNT0 : GNT1;
        else if (bus.m0_req)          state_d = GNT0;
        else if (bus.m1_req)          state_d = GNT1;
      end
      GNT0: begin
        if (!bus.m0_req)                      state_d = bus.m1_req ? GNT1 : IDLE;
        else if (bus.m1_req && hold_expired)  state_d = GNT1;
      end
      GNT1: begin
        if (!bus.m1_req)                      state_d = bus.m0_req ? GNT0 : IDLE;
        else if (bus.m0_req && hold_expired)  state_d = GNT0;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) begin
      hold_cnt_d = '0;
    end else if (state_d != state_q) begin
      hold_cnt_d   = '0;
      last_owner_d = (state_d == GNT1);
    end else if (hold_cnt_q != CNT_W'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  assign any_gnt  = (state_q == GNT0) || (state_q == GNT1);
  assign per1_hit = (bus.bus_addr[31:4] == PER1_BASE[31:4]);

  always_comb begin
    bus.m0_gnt    = (state_q == GNT0);
    bus.m1_gnt    = (state_q == GNT1);
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    bus.bus_we    = '0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;

    if (state_q == GNT0) begin
      bus.bus_addr  = bus.m0_addr;
      bus.bus_wdata = bus.m0_wdata;
      bus.bus_we    = bus.m0_we;
      bus.m0_rdata  = bus.bus_rdata;
    end else if (state_q == GNT1) begin
      bus.bus_addr  = bus.m1_addr;
      bus.bus_wdata = bus.m1_wdata;
      bus.bus_we    = bus.m1_we;
      bus.m1_rdata  = bus.bus_rdata;
    end

    bus.ce[1] = any_gnt && per1_hit;
    bus.ce[0] = any_gnt && !per1_hit;
  end

endmodule

// File: tb/tb_bus_master_arb.sv
// Directed-vector bench for bus_master_arb: reset, grant latency, decode,
// fairness rotation, handover, restart after drop and asynchronous reset abort.
module tb_bus_master_arb;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bus_master_arb_if bif ();

  bus_master_arb #(
    .MAX_HOLD (8),
    .PER1_BASE(32'h0000_0080)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m0_gnt"}, 32'(bif.m0_gnt), 32'd0);
    check({tag, "_m1_gnt"}, 32'(bif.m1_gnt), 32'd0);
    check({tag, "_ce"}, 32'(bif.ce), 32'd0);
    check({tag, "_bus_we"}, 32'(bif.bus_we), 32'd0);
    check({tag, "_bus_addr"}, bif.bus_addr, 32'd0);
    check({tag, "_bus_wdata"}, bif.bus_wdata, 32'd0);
    check({tag, "_m0_rdata"}, bif.m0_rdata, 32'd0);
    check({tag, "_m1_rdata"}, bif.m1_rdata, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bif.m0_req    = 1'b0;
    bif.m1_req    = 1'b0;
    bif.m0_addr   = 32'h0000_0084;
    bif.m1_addr   = 32'h0000_0040;
    bif.m0_wdata  = 32'h0000_0001;
    bif.m1_wdata  = 32'h0000_0002;
    bif.m0_we     = 4'hF;
    bif.m1_we     = 4'h3;
    bif.bus_rdata = 32'h1234_5678;

    // Reset holds everything quiet even with a live request.
    bif.m0_req = 1'b1;
    tick();
    tick();
    check_idle_outputs("rst");

    // Release: first grant follows the first edge after release.
    reset = 1'b0;
    check("rel_no_gnt", 32'(bif.m0_gnt), 32'd0);
    tick();
    check("w84_m0_gnt", 32'(bif.m0_gnt), 32'd1);
    check("w84_m1_gnt", 32'(bif.m1_gnt), 32'd0);
    check("w84_ce", 32'(bif.ce), 32'd2);
    check("w84_wdata", bif.bus_wdata, 32'h0000_0001);
    check("w84_we", 32'(bif.bus_we), 32'hF);
    check("w84_addr", bif.bus_addr, 32'h0000_0084);
    check("w84_m0_rdata", bif.m0_rdata, 32'h1234_5678);
    check("w84_m1_rdata", bif.m1_rdata, 32'd0);

    // Sole requester keeps the grant for 20 cycles; counter saturates.
    for (int i = 1; i < 20; i++) begin
      tick();
      check("sole_m0_gnt", 32'(bif.m0_gnt), 32'd1);
    end
    check("hold_sat", 32'(dut.hold_cnt_q), 32'd8);

    // Handover with no idle cycle; m1 at peripheral 0 with read data.
    bif.m0_req    = 1'b0;
    bif.m1_req    = 1'b1;
    bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    check("ho_m1_gnt", 32'(bif.m1_gnt), 32'd1);
    check("ho_m0_gnt", 32'(bif.m0_gnt), 32'd0);
    check("p0_ce", 32'(bif.ce), 32'd1);
    check("p0_m1_rdata", bif.m1_rdata, 32'hDEAD_BEEF);
    check("p0_m0_rdata", bif.m0_rdata, 32'd0);
    check("p0_we", 32'(bif.bus_we), 32'h3);
    check("p0_addr", bif.bus_addr, 32'h0000_0040);
    check("p0_wdata", bif.bus_wdata, 32'h0000_0002);

    // m1 drops: back to idle.
    bif.m1_req = 1'b0;
    tick();
    check_idle_outputs("idle");

    // Tie from reset: m0 first, then rotation every 8 granted cycles.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    bif.m0_req = 1'b1;
    bif.m1_req = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 8; k++) begin
        check("rr_m0_gnt", 32'(bif.m0_gnt), (p % 2 == 0) ? 32'd1 : 32'd0);
        check("rr_m1_gnt", 32'(bif.m1_gnt), (p % 2 == 1) ? 32'd1 : 32'd0);
        tick();
      end
    end

    // Drop and re-request: last owner was m0 here, so the tie goes to m1.
    bif.m1_req = 1'b0;
    tick();
    check("rq_m0_gnt", 32'(bif.m0_gnt), 32'd1);
    bif.m0_req = 1'b0;
    tick();
    check("rq_idle", 32'(bif.m0_gnt | bif.m1_gnt), 32'd0);
    bif.m0_req = 1'b1;
    bif.m1_req = 1'b1;
    tick();
    check("rq_tie_m1", 32'(bif.m1_gnt), 32'd1);
    check("rq_tie_m0", 32'(bif.m0_gnt), 32'd0);

    // m1 writes to peripheral 1, then reset mid-grant aborts asynchronously.
    bif.m0_req  = 1'b0;
    bif.m1_addr = 32'h0000_0088;
    bif.m1_we   = 4'hF;
    tick();
    check("w88_m1_gnt", 32'(bif.m1_gnt), 32'd1);
    check("w88_ce", 32'(bif.ce), 32'd2);
    check("w88_we", 32'(bif.bus_we), 32'hF);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async");
    tick();
    check_idle_outputs("rst_hold");
    reset = 1'b0;
    tick();
    check("regnt_m1", 32'(bif.m1_gnt), 32'd1);
    check("regnt_ce", 32'(bif.ce), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_master_arb.md
BUS_MASTER_ARB -- requirements
Module: bus_master_arb

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the consecutive granted cycles after which a holder yields to a waiting requester.
REQ-002 Parameter PER1_BASE, default 32'h0000_0080, SHALL set the 16-byte window decoded to peripheral 1.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 m0_req, m1_req  input  1 each  SHALL be the master bus requests; m0 = CPU, m1 = DMA.
REQ-006 m0_addr, m1_addr  input  32 each  SHALL be the master byte addresses.
REQ-007 m0_wdata, m1_wdata  input  32 each  SHALL be the master write data.
REQ-008 m0_we, m1_we  input  4 each  SHALL be the master byte write enables.
REQ-009 m0_gnt, m1_gnt  output  1 each  SHALL be the registered grants; at most one high.
REQ-010 m0_rdata, m1_rdata  output  32 each  SHALL return read data to the masters.
REQ-011 bus_addr, bus_wdata  output  32 each  SHALL drive the shared peripheral bus.
REQ-012 bus_we  output  4  SHALL be the shared-bus byte write enable.
REQ-013 ce  output  2  SHALL be the peripheral chip enables; ce[1] peripheral 1, ce[0] peripheral 0.
REQ-014 bus_rdata  input  32  SHALL be the selected peripheral read data.

Function
REQ-015 FSM states SHALL be IDLE, GNT0, GNT1; grants are Moore outputs: m0_gnt = (state==GNT0), m1_gnt = (state==GNT1).
REQ-016 IDLE: no req -> IDLE; one req -> that master's GNT state; both req -> master other than last_owner.
REQ-017 last_owner SHALL update on every entry to GNT0/GNT1 and reset to 1 (m0 wins the first tie).
REQ-018 Grant latency SHALL be one cycle: req sampled high at edge N -> gnt high after edge N.
REQ-019 GNTx with own req low -> GNTy if other req high, else IDLE; no dead cycle on handover.
REQ-020 hold_cnt SHALL clear on entry to any GNT state, increment per granted cycle, saturate at MAX_HOLD.
REQ-021 GNTx with hold_cnt == MAX_HOLD-1 and other req high -> GNTy on the next edge regardless of own req.
REQ-022 GNTx with own req high and other req low -> stay, counter saturating, grant never dropped.
REQ-023 bus_addr, bus_wdata, bus_we SHALL combinationally mux the granted master's signals; with no grant, bus_addr = bus_wdata = 0, bus_we = 4'b0000.
REQ-024 ce[1] SHALL equal any_gnt AND (bus_addr[31:4] == PER1_BASE[31:4]); ce[0] SHALL equal any_gnt AND NOT ce[1]; ce = 2'b00 in IDLE.
REQ-025 Granted master's rdata SHALL equal bus_rdata; non-granted master's rdata SHALL be 32'h0.
REQ-026 Writes from a non-granted master SHALL never reach bus_we.
REQ-027 Dropping and re-asserting req within one cycle SHALL be treated as a new request subject to REQ-016.

Reset
REQ-028 reset high SHALL immediately force state = IDLE, hold_cnt = 0, last_owner = 1, m0_gnt = m1_gnt = 0, ce = 2'b00, bus_we = 0, bus_addr = bus_wdata = 0, m0_rdata = m1_rdata = 0.
REQ-029 reset asserted mid-grant SHALL abort the transfer with no further bus_we; first grant SHALL follow the first edge after release.

Verification
REQ-030 Reset then m0_req=1, m0_addr=32'h84, m0_we=4'hF, m0_wdata=32'h1 -> m0_gnt high next cycle, ce=2'b10, bus_wdata=32'h1, bus_we=4'hF.
REQ-031 m0_req and m1_req asserted same edge from reset -> m0 granted first; both held -> after 8 granted cycles m1_gnt high, m0_gnt low, then alternate every 8.
REQ-032 m1 granted at addr 32'h40, bus_rdata=32'hDEAD_BEEF -> ce=2'b01, m1_rdata=32'hDEAD_BEEF, m0_rdata=0.
REQ-033 m0 sole requester for 20 cycles -> m0_gnt stays high all 20 cycles, hold_cnt saturates at 8.
REQ-034 m0 drops req while m1_req high -> m1_gnt high next edge, no IDLE cycle.
REQ-035 reset pulsed during m1 write to 32'h88 -> grants, ce, bus_we zero asynchronously; m1 regranted one cycle after release.
